// File: rtl/gpioemu_pkg.sv
// rtl/gpioemu_pkg.sv - shared types and constants for the two-requester multiplier arbiter
package gpioemu_pkg;

    localparam int MUL_W = 24;
    localparam int POP_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        COUNT,
        DONE
    } state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - request/grant and result bundle between requesters and the arbiter
interface mul_arbiter_if #(
    parameter int MUL_W = gpioemu_pkg::MUL_W
);

    logic [1:0]                    req;
    logic [MUL_W-1:0]              a1_0;
    logic [MUL_W-1:0]              a2_0;
    logic [MUL_W-1:0]              a1_1;
    logic [MUL_W-1:0]              a2_1;
    logic [1:0]                    gnt;
    logic [1:0]                    done;
    logic [31:0]                   w;
    logic [gpioemu_pkg::POP_W-1:0] l;
    logic                          valid;
    logic                          busy;

    modport master (
        output req, a1_0, a2_0, a1_1, a2_1,
        input  gnt, done, w, l, valid, busy
    );

    modport slave (
        input  req, a1_0, a2_0, a1_1, a2_1,
        output gnt, done, w, l, valid, busy
    );

endinterface

// File: rtl/mul_shift_add.sv
// rtl/mul_shift_add.sv - sequential shift-add multiplier, one partial product per step
module mul_shift_add #(
    parameter int MUL_W = gpioemu_pkg::MUL_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 step,
    input  logic [MUL_W-1:0]     a1,
    input  logic [MUL_W-1:0]     a2,
    output logic [2*MUL_W-1:0]   product
);

    localparam int PROD_W = 2 * MUL_W;

    // Multiplicand is kept full product width so the left shifts never lose bits.
    logic [PROD_W-1:0] mcand;
    logic [MUL_W-1:0]  mplier;
    logic [PROD_W-1:0] acc;

    // Load operands on start; each step adds the shifted multiplicand when the current multiplier LSB is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (step && mplier[0]) begin
                acc <= acc + mcand;
            end

            if (start) begin
                mcand  <= PROD_W'(a1);
                mplier <= a2;
            end else if (step) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one shift-add multiplier between two requesters
module mul_arbiter #(
    parameter int MUL_W = gpioemu_pkg::MUL_W
) (
    input  logic          clk,
    input  logic          reset,
    mul_arbiter_if.slave  bus
);

    import gpioemu_pkg::*;

    localparam int CNT_W  = $clog2(MUL_W);
    localparam int PROD_W = 2 * MUL_W;

    state_t             state;
    logic [CNT_W-1:0]   step_cnt;
    logic               last_gnt;
    logic               owner;
    logic [POP_W-1:0]   pop_cnt;
    logic [POP_W-1:0]   pop_next;

    logic [1:0]         gnt_r;
    logic [1:0]         done_r;
    logic [31:0]        w_r;
    logic [POP_W-1:0]   l_r;
    logic               valid_r;
    logic               busy_r;

    logic               grant;
    logic               pick;
    logic               step;
    logic [MUL_W-1:0]   a1_sel;
    logic [MUL_W-1:0]   a2_sel;
    logic [PROD_W-1:0]  product;

    // Round-robin choice: on a tie the requester not granted last wins; otherwise whoever is asking.
    assign grant  = (state == IDLE) && (|bus.req);
    assign pick   = (bus.req == 2'b11) ? ~last_gnt : bus.req[1];
    assign a1_sel = pick ? bus.a1_1 : bus.a1_0;
    assign a2_sel = pick ? bus.a2_1 : bus.a2_0;
    assign step   = (state == MULT);

    mul_shift_add #(
        .MUL_W(MUL_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (grant),
        .clear   (grant),
        .step    (step),
        .a1      (a1_sel),
        .a2      (a2_sel),
        .product (product)
    );

    // Popcount of the low product word, registered during COUNT.
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < 32; i++) begin
            pop_next = pop_next + POP_W'(product[i]);
        end
    end

    // Job sequencer: IDLE grants, MULT runs a fixed MUL_W steps, COUNT latches the popcount, DONE publishes results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            pop_cnt  <= '0;
            gnt_r    <= '0;
            done_r   <= '0;
            w_r      <= '0;
            l_r      <= '0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            gnt_r  <= '0;
            done_r <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_r    <= pick ? 2'b10 : 2'b01;
                        owner    <= pick;
                        last_gnt <= pick;
                        step_cnt <= '0;
                        busy_r   <= 1'b1;
                        state    <= MULT;
                    end
                end
                MULT: begin
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == CNT_W'(MUL_W - 1)) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    pop_cnt <= pop_next;
                    state   <= DONE;
                end
                DONE: begin
                    w_r     <= product[31:0];
                    l_r     <= pop_cnt;
                    valid_r <= ~|product[PROD_W-1:32];
                    done_r  <= owner ? 2'b10 : 2'b01;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.done  = done_r;
    assign bus.w     = w_r;
    assign bus.l     = l_r;
    assign bus.valid = valid_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed self-checking bench for mul_arbiter
module tb_mul_arbiter;

    localparam int W = gpioemu_pkg::MUL_W;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mul_arbiter_if bus ();

    mul_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [1:0]  m_gnt;
    logic [1:0]  m_done;
    logic [31:0] m_w;
    logic [5:0]  m_l;
    logic        m_valid;
    logic        m_busy;
    int          m_left;
    logic        m_owner;
    logic        m_last;
    logic [63:0] m_prod;
    bit          m_live = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] mult(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] x;
        logic [63:0] y;
        x = 64'(a);
        y = 64'(b);
        return x * y;
    endfunction

    // Reference: a job is a countdown of W+2 cycles from grant to done, product from plain multiplication.
    always @(posedge clk) begin
        cyc++;
        m_gnt  = 2'b00;
        m_done = 2'b00;
        if (reset) begin
            m_w = 0; m_l = 0; m_valid = 0; m_busy = 0;
            m_left = 0; m_last = 1; m_owner = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done  = m_owner ? 2'b10 : 2'b01;
                m_w     = m_prod[31:0];
                m_l     = 6'($countones(m_prod[31:0]));
                m_valid = (m_prod[63:32] == 0);
                m_busy  = 0;
            end
        end else if (bus.req != 2'b00) begin
            m_owner = (bus.req == 2'b11) ? !m_last : bus.req[1];
            m_prod  = m_owner ? mult(bus.a1_1, bus.a2_1) : mult(bus.a1_0, bus.a2_0);
            m_gnt   = m_owner ? 2'b10 : 2'b01;
            m_last  = m_owner;
            m_left  = W + 2;
            m_busy  = 1;
        end
        m_live = 1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cycle_outputs",
                  {20'h0, bus.gnt, bus.done, bus.w, bus.l, bus.valid, bus.busy},
                  {20'h0, m_gnt, m_done, m_w, m_l, m_valid, m_busy});
        end
    end

    task automatic wait_gnt(output int t, output logic [1:0] g);
        t = -1000;
        g = 2'b00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) begin
                g = bus.gnt;
                t = cyc;
                return;
            end
        end
    endtask

    task automatic wait_done(output int t, output logic [1:0] d);
        t = -1000;
        d = 2'b00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done != 2'b00) begin
                d = bus.done;
                t = cyc;
                return;
            end
        end
    endtask

    int         tg, td, tr, t1, t2;
    logic [1:0] g, d;
    int         seen0;

    initial begin
        bus.req  = 2'b00;
        bus.a1_0 = '0; bus.a2_0 = '0;
        bus.a1_1 = '0; bus.a2_1 = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'h0, bus.gnt, bus.done, bus.w, bus.l, bus.valid, bus.busy}, 64'h0);
        reset = 1'b0;

        // Scenario 1: 3*5
        bus.a1_0 = 3; bus.a2_0 = 5; bus.req = 2'b01;
        wait_gnt(tg, g);
        bus.req = 2'b00;
        check("s1_gnt", g, 2'b01);
        wait_done(td, d);
        check("s1_done", d, 2'b01);
        check("s1_latency", td - tg, 26);
        check("s1_w", bus.w, 15);
        check("s1_l", bus.l, 4);
        check("s1_valid", bus.valid, 1);

        // Scenario 2: full-scale operands overflow 32 bits
        bus.a1_1 = 24'hFFFFFF; bus.a2_1 = 24'hFFFFFF; bus.req = 2'b10;
        wait_gnt(tg, g);
        bus.req = 2'b00;
        check("s2_gnt", g, 2'b10);
        wait_done(td, d);
        check("s2_done", d, 2'b10);
        check("s2_latency", td - tg, 26);
        check("s2_w", bus.w, 32'hFE000001);
        check("s2_l", bus.l, 8);
        check("s2_valid", bus.valid, 0);

        // Scenario 6: zero multiplicand keeps full latency
        bus.a1_0 = 0; bus.a2_0 = 24'h123456; bus.req = 2'b01;
        wait_gnt(tg, g);
        bus.req = 2'b00;
        check("s6_gnt", g, 2'b01);
        wait_done(td, d);
        check("s6_latency", td - tg, 26);
        check("s6_w", bus.w, 0);
        check("s6_l", bus.l, 0);
        check("s6_valid", bus.valid, 1);

        // Scenario 3: both request right after reset; then owner 1 alone re-requests across its done
        @(negedge clk);
        reset = 1'b1;
        bus.a1_0 = 7; bus.a2_0 = 9; bus.a1_1 = 10; bus.a2_1 = 11;
        @(negedge clk);
        reset = 1'b0;
        bus.req = 2'b11;
        tr = cyc;
        wait_gnt(tg, g);
        check("s3_gnt0", g, 2'b01);
        check("s3_gnt0_time", tg - tr, 1);
        wait_done(td, d);
        check("s3_done0", d, 2'b01);
        check("s3_latency0", td - tg, 26);
        check("s3_w0", bus.w, 63);
        wait_gnt(t1, g);
        bus.req = 2'b10;
        check("s3_gnt1", g, 2'b10);
        check("s3_gnt_gap", t1 - tg, 27);
        wait_done(td, d);
        check("s3_done1", d, 2'b10);
        check("s3_w1", bus.w, 110);
        check("s3_l1", bus.l, 5);
        wait_gnt(t2, g);
        bus.req = 2'b00;
        check("s3_regrant", g, 2'b10);
        check("s3_regrant_gap", t2 - t1, 27);
        wait_done(td, d);
        check("s3_done2", d, 2'b10);

        // Scenario 4: reset mid-job aborts it
        bus.a1_0 = 5; bus.a2_0 = 5; bus.req = 2'b01;
        wait_gnt(tg, g);
        bus.req = 2'b00;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("s4_abort", {20'h0, bus.gnt, bus.done, bus.w, bus.l, bus.valid, bus.busy}, 64'h0);
        reset = 1'b0;
        bus.a1_1 = 6; bus.a2_1 = 7; bus.req = 2'b10;
        tr = cyc;
        wait_gnt(tg, g);
        bus.req = 2'b00;
        check("s4_gnt", g, 2'b10);
        check("s4_gnt_time", tg - tr, 1);
        wait_done(td, d);
        check("s4_done", d, 2'b10);
        check("s4_w", bus.w, 42);

        // Scenario 5: short request while busy never becomes a job
        bus.a1_1 = 2; bus.a2_1 = 2; bus.req = 2'b10;
        wait_gnt(tg, g);
        bus.req = 2'b00;
        repeat (5) @(negedge clk);
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        seen0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gnt[0] || bus.done[0]) seen0++;
        end
        check("s5_no_job", seen0, 0);
        check("s5_w", bus.w, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
